// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: pipeline-register update
// commands, sequencer states and the width of the execute wait counter.
package pipe_ctrl_pkg;

  localparam int CNT_BITS = 5;

  localparam logic [1:0] UPD_HOLD  = 2'b00;
  localparam logic [1:0] UPD_ADV   = 2'b01;
  localparam logic [1:0] UPD_FLUSH = 2'b10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EXWAIT = 2'd1,
    HALT   = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pipeline_ctrl_reg_match.sv
// Hazard compare of one decode source against the E-stage destination.
// Register 0 is deliberately not excluded.
module reg_match (
  input  logic [1:0] rw,
  input  logic [4:0] rd,
  input  logic [5:0] r,
  input  logic       use_r,
  output logic       hit
);

  assign hit = use_r && (rw != 2'b00) && (rw[1] == r[5]) && (rd == r[4:0]);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: derives fd/de/ew update commands and PC control from
// hazards, branches, multi-cycle execute, stop and memory stalls.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          d_rs,
  input  logic [5:0]          d_rt,
  input  logic                d_use_s,
  input  logic                d_use_t,
  input  logic [1:0]          de_rw,
  input  logic [4:0]          de_rd,
  input  logic [4:0]          de_wait_time,
  input  logic                e_branch,
  input  logic                de_stop,
  input  logic                mem_stall,
  input  logic                resume,
  output logic [1:0]          fd_update,
  output logic [1:0]          de_update,
  output logic [1:0]          ew_update,
  output logic                pc_en,
  output logic                pc_sel,
  output logic                halted,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
  output pc_state_t           state_dbg,
  output logic [CNT_BITS-1:0] cnt_dbg
);

  pc_state_t           state, state_n;
  logic [CNT_BITS-1:0] cnt, cnt_n;
  logic [CNT_BITS-1:0] wait_eff;
  logic                hit_s, hit_t;
  logic                final_cyc, stall_inc, flush_inc;

  reg_match u_match_s (.rw(de_rw), .rd(de_rd), .r(d_rs), .use_r(d_use_s), .hit(hit_s));
  reg_match u_match_t (.rw(de_rw), .rd(de_rd), .r(d_rt), .use_r(d_use_t), .hit(hit_t));

  assign wait_eff  = (de_wait_time == '0) ? CNT_BITS'(1) : de_wait_time;
  assign halted    = (state == HALT);
  assign state_dbg = state;
  assign cnt_dbg   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    fd_update = UPD_HOLD;
    de_update = UPD_HOLD;
    ew_update = UPD_HOLD;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    state_n   = state;
    cnt_n     = cnt;
    final_cyc = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (rst) begin
      fd_update = UPD_FLUSH;
      de_update = UPD_FLUSH;
      ew_update = UPD_FLUSH;
      state_n   = RUN;
      cnt_n     = '0;
    end else if (!mem_stall) begin
      unique case (state)
        HALT: begin
          ew_update = UPD_FLUSH;
          if (resume) state_n = RUN;
        end
        RUN: begin
          if (wait_eff > CNT_BITS'(1)) begin
            ew_update = UPD_FLUSH;
            cnt_n     = wait_eff - CNT_BITS'(1);
            state_n   = EXWAIT;
            stall_inc = 1'b1;
          end else begin
            final_cyc = 1'b1;
          end
        end
        EXWAIT: begin
          if (cnt > CNT_BITS'(1)) begin
            ew_update = UPD_FLUSH;
            cnt_n     = cnt - CNT_BITS'(1);
            stall_inc = 1'b1;
          end else begin
            cnt_n     = '0;
            state_n   = RUN;
            final_cyc = 1'b1;
          end
        end
        default: state_n = RUN;
      endcase

      // E's final cycle: stop beats branch, branch squashes a hazarding D.
      if (final_cyc) begin
        if (de_stop) begin
          fd_update = UPD_FLUSH;
          de_update = UPD_FLUSH;
          ew_update = UPD_ADV;
          state_n   = HALT;
        end else if (e_branch) begin
          fd_update = UPD_FLUSH;
          de_update = UPD_FLUSH;
          ew_update = UPD_ADV;
          pc_en     = 1'b1;
          pc_sel    = 1'b1;
          flush_inc = 1'b1;
        end else if (hit_s || hit_t) begin
          de_update = UPD_FLUSH;
          ew_update = UPD_ADV;
          stall_inc = 1'b1;
        end else begin
          fd_update = UPD_ADV;
          de_update = UPD_ADV;
          ew_update = UPD_ADV;
          pc_en     = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios followed by random stimulus,
// all compared against an occupancy-based reference model.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       d_rs, d_rt;
  logic             d_use_s, d_use_t;
  logic [1:0]       de_rw;
  logic [4:0]       de_rd;
  logic [4:0]       de_wait_time;
  logic             e_branch, de_stop, mem_stall, resume;
  logic [1:0]       fd_update, de_update, ew_update;
  logic             pc_en, pc_sel, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  pc_state_t        state_dbg;
  logic [4:0]       cnt_dbg;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_s(d_use_s), .d_use_t(d_use_t), .de_rw(de_rw), .de_rd(de_rd),
    .de_wait_time(de_wait_time), .e_branch(e_branch), .de_stop(de_stop),
    .mem_stall(mem_stall), .resume(resume),
    .fd_update(fd_update), .de_update(de_update), .ew_update(ew_update),
    .pc_en(pc_en), .pc_sel(pc_sel), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .state_dbg(state_dbg), .cnt_dbg(cnt_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: m_left counts remaining E-stage cycles of the current instruction
  // (0 = no multi-cycle instruction in progress).
  int          m_left   = 0;
  bit          m_halted = 0;
  logic [31:0] m_stall  = 0;
  logic [31:0] m_flush  = 0;

  task automatic set_idle();
    rst = 0; mem_stall = 0; resume = 0; de_stop = 0; e_branch = 0;
    de_wait_time = 5'd1; de_rw = 2'b00; de_rd = 5'd0;
    d_rs = 6'd0; d_rt = 6'd0; d_use_s = 0; d_use_t = 0;
  endtask

  task automatic step();
    logic [1:0] e_fd, e_de, e_ew;
    bit         e_pc, e_sel, hz;
    int         n_left;
    bit         n_halted;
    logic [31:0] n_stall, n_flush;
    pc_state_t  e_state;

    @(negedge clk);
    e_fd = 2'b00; e_de = 2'b00; e_ew = 2'b00; e_pc = 0; e_sel = 0;
    n_left = m_left; n_halted = m_halted; n_stall = m_stall; n_flush = m_flush;
    hz = (de_rw != 0) && ((d_use_s && d_rs == {de_rw[1], de_rd}) ||
                          (d_use_t && d_rt == {de_rw[1], de_rd}));
    if (rst) begin
      e_fd = 2'b10; e_de = 2'b10; e_ew = 2'b10;
      n_left = 0; n_halted = 0; n_stall = 0; n_flush = 0;
    end else if (mem_stall) begin
      // everything frozen
    end else if (m_halted) begin
      e_ew = 2'b10;
      if (resume) n_halted = 0;
    end else begin
      if (n_left == 0) n_left = (de_wait_time == 0) ? 1 : int'(de_wait_time);
      if (n_left > 1) begin
        e_ew = 2'b10;
        n_left--;
        n_stall++;
      end else begin
        n_left = 0;
        if (de_stop) begin
          e_fd = 2'b10; e_de = 2'b10; e_ew = 2'b01; n_halted = 1;
        end else if (e_branch) begin
          e_fd = 2'b10; e_de = 2'b10; e_ew = 2'b01; e_pc = 1; e_sel = 1;
          n_flush++;
        end else if (hz) begin
          e_de = 2'b10; e_ew = 2'b01; n_stall++;
        end else begin
          e_fd = 2'b01; e_de = 2'b01; e_ew = 2'b01; e_pc = 1;
        end
      end
    end

    check("fd_update", 32'(fd_update), 32'(e_fd));
    check("de_update", 32'(de_update), 32'(e_de));
    check("ew_update", 32'(ew_update), 32'(e_ew));
    check("pc_en",     32'(pc_en),     32'(e_pc));
    if (e_pc) check("pc_sel", 32'(pc_sel), 32'(e_sel));
    check("halted",    32'(halted),    32'(m_halted));

    @(posedge clk);
    #1;
    m_left = n_left; m_halted = n_halted; m_stall = n_stall; m_flush = n_flush;
    e_state = m_halted ? HALT : ((m_left > 0) ? EXWAIT : RUN);
    check("state",     32'(state_dbg), 32'(e_state));
    check("cnt",       32'(cnt_dbg),   32'(m_left));
    check("stall_cnt", stall_cnt,      m_stall);
    check("flush_cnt", flush_cnt,      m_flush);
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    step();                                   // checked reset cycle

    repeat (5) step();                        // straight-line code

    de_rw = 2'b01; de_rd = 5'd5; d_rs = 6'd5; d_use_s = 1;
    step();                                   // load-use hazard
    de_rw = 2'b01; de_rd = 5'd5; d_rs = 6'd37; d_use_s = 1;
    step();                                   // FPU-file source: no hazard

    for (int i = 0; i < 4; i++) begin         // wait 4 with branch held
      de_wait_time = 5'd4; e_branch = 1;
      step();
    end
    step();

    de_wait_time = 5'd3; step();              // wait 3, stalled twice inside
    mem_stall = 1; step();
    mem_stall = 1; step();
    step(); step(); step();

    de_stop = 1; step();                      // stop, then halt until resume
    repeat (3) step();
    resume = 1; step();
    step();

    de_wait_time = 5'd5; step(); step();      // reset mid-EXWAIT
    rst = 1; step();
    step();
    de_stop = 1; step(); step();              // reset in HALT
    rst = 1; step();
    step();

    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      mem_stall    = ($urandom_range(0, 5) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      de_stop      = ($urandom_range(0, 14) == 0);
      e_branch     = ($urandom_range(0, 4) == 0);
      de_wait_time = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 6))
                                                 : 5'($urandom_range(0, 1));
      de_rw        = 2'($urandom_range(0, 3));
      de_rd        = 5'($urandom_range(0, 3));
      d_rs         = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      d_rt         = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))};
      d_use_s      = 1'($urandom_range(0, 1));
      d_use_t      = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
